// File: rtl/cp0_core.sv
// CP0 for the WB stage: Status/Cause/EPC/BadVAddr, exception/interrupt priority and redirect; Count/Compare timer under CP0_COUNT_TIMER_EN.
// Outputs are combinational in the WB cycle, state updates at the next edge; no backpressure (wb_valid=0 just holds state).
module cp0_core #(
    parameter int          HW_INT_NUM = 6,
    parameter int          COUNT_DIV  = 2,
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  wb_valid,
    input  logic [31:0]           wb_pc,
    input  logic                  wb_delay_slot,
    input  logic [6:0]            exc_flags,
    input  logic [31:0]           wb_dm_addr,
    input  logic                  mtc0,
    input  logic                  mfc0,
    input  logic                  eret,
    input  logic [7:0]            cp0_addr,
    input  logic [31:0]           cp0_wdata,
    input  logic [HW_INT_NUM-1:0] hw_int,
    output logic [31:0]           cp0_rdata,
    output logic                  exc_valid,
    output logic [31:0]           exc_pc,
    output logic                  cancel,
    output logic                  commit_block
);

    localparam logic [7:0] A_BADV    = {5'd8,  3'd0};
    localparam logic [7:0] A_COUNT   = {5'd9,  3'd0};
    localparam logic [7:0] A_COMPARE = {5'd11, 3'd0};
    localparam logic [7:0] A_STATUS  = {5'd12, 3'd0};
    localparam logic [7:0] A_CAUSE   = {5'd13, 3'd0};
    localparam logic [7:0] A_EPC     = {5'd14, 3'd0};

    logic [HW_INT_NUM-1:0] hw_s1, hw_s2;
    logic [5:0]  hw_ip;
    logic [7:0]  st_im;
    logic        st_exl, st_ie;
    logic        cause_bd, cause_ti;
    logic [1:0]  cause_ipsw;
    logic [4:0]  cause_exc;
    logic [7:0]  cause_ip;
    logic [31:0] epc, badvaddr;
    logic        int_pend;
    logic [31:0] status_val, cause_val, count_val, compare_val, rd_val;
    logic        exc_any, take, wen;
    logic [4:0]  exc_code;
    logic        bad_upd;
    logic [31:0] bad_val;

    always_comb begin
        hw_ip = '0;
        hw_ip[HW_INT_NUM-1:0] = hw_s2;
    end

    assign cause_ip   = {hw_ip[5] | cause_ti, hw_ip[4:0], cause_ipsw};
    assign status_val = {9'b0, 1'b1, 6'b0, st_im, 6'b0, st_exl, st_ie};
    assign cause_val  = {cause_bd, cause_ti, 14'b0, cause_ip, 1'b0, cause_exc, 2'b0};

    assign exc_any = int_pend | (|exc_flags);
    assign take    = wb_valid & exc_any;
    assign wen     = wb_valid & mtc0 & ~exc_any;

    always_comb begin
        exc_code = 5'd0;
        bad_upd  = 1'b0;
        bad_val  = wb_dm_addr;
        if (int_pend)          exc_code = 5'd0;
        else if (exc_flags[6]) begin exc_code = 5'd4; bad_upd = 1'b1; bad_val = wb_pc; end
        else if (exc_flags[5]) exc_code = 5'd10;
        else if (exc_flags[4]) exc_code = 5'd12;
        else if (exc_flags[3]) exc_code = 5'd8;
        else if (exc_flags[2]) exc_code = 5'd9;
        else if (exc_flags[1]) begin exc_code = 5'd4; bad_upd = 1'b1; end
        else if (exc_flags[0]) begin exc_code = 5'd5; bad_upd = 1'b1; end
    end

    // Gating with resetn keeps the redirect quiet while the pipeline is held in reset.
    assign exc_valid    = resetn & wb_valid & (exc_any | eret);
    assign exc_pc       = exc_any ? EXC_VECTOR : epc;
    assign cancel       = exc_valid;
    assign commit_block = resetn & take;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            hw_s1      <= '0;
            hw_s2      <= '0;
            int_pend   <= 1'b0;
            st_im      <= '0;
            st_exl     <= 1'b0;
            st_ie      <= 1'b0;
            cause_bd   <= 1'b0;
            cause_ipsw <= '0;
            cause_exc  <= '0;
            epc        <= '0;
            badvaddr   <= '0;
        end else begin
            hw_s1    <= hw_int;
            hw_s2    <= hw_s1;
            int_pend <= (|(cause_ip & st_im)) & st_ie & ~st_exl;
            if (take) begin
                st_exl    <= 1'b1;
                cause_bd  <= wb_delay_slot;
                epc       <= wb_delay_slot ? wb_pc - 32'd4 : wb_pc;
                cause_exc <= exc_code;
                if (bad_upd) badvaddr <= bad_val;
            end else begin
                if (wb_valid && eret) st_exl <= 1'b0;
                if (wen) begin
                    case (cp0_addr)
                        A_STATUS: begin
                            st_im  <= cp0_wdata[15:8];
                            st_exl <= cp0_wdata[1];
                            st_ie  <= cp0_wdata[0];
                        end
                        A_CAUSE: cause_ipsw <= cp0_wdata[9:8];
                        A_EPC:   epc        <= cp0_wdata;
                        default: ;
                    endcase
                end
            end
        end
    end

`ifdef CP0_COUNT_TIMER_EN
    localparam logic [3:0] PRE_MAX = 4'(COUNT_DIV - 1);

    logic [31:0] count, compare;
    logic [3:0]  pre;
    logic        armed, ti;

    // armed stops the reset-time Count==Compare==0 match from raising TI.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            count   <= '0;
            compare <= '0;
            pre     <= '0;
            armed   <= 1'b0;
            ti      <= 1'b0;
        end else begin
            if (wen && cp0_addr == A_COUNT) begin
                count <= cp0_wdata;
                pre   <= '0;
            end else if (pre == PRE_MAX) begin
                pre   <= '0;
                count <= count + 32'd1;
            end else begin
                pre <= pre + 4'd1;
            end
            if (wen && cp0_addr == A_COMPARE) begin
                compare <= cp0_wdata;
                armed   <= 1'b1;
                ti      <= 1'b0;
            end else if (armed && count == compare) begin
                ti <= 1'b1;
            end
        end
    end

    assign count_val   = count;
    assign compare_val = compare;
    assign cause_ti    = ti;
`else
    assign count_val   = '0;
    assign compare_val = '0;
    assign cause_ti    = 1'b0;
`endif

    always_comb begin
        rd_val = '0;
        case (cp0_addr)
            A_BADV:    rd_val = badvaddr;
            A_COUNT:   rd_val = count_val;
            A_COMPARE: rd_val = compare_val;
            A_STATUS:  rd_val = status_val;
            A_CAUSE:   rd_val = cause_val;
            A_EPC:     rd_val = epc;
            default:   rd_val = '0;
        endcase
    end

    assign cp0_rdata = mfc0 ? rd_val : 32'd0;

endmodule

// File: tb/tb_cp0_core.sv
// Directed bench for cp0_core: reset, exceptions, priority, mtc0/eret, timer (when enabled) and hardware interrupts.
module tb_cp0_core;

    localparam logic [7:0] A_BADV    = {5'd8,  3'd0};
    localparam logic [7:0] A_COUNT   = {5'd9,  3'd0};
    localparam logic [7:0] A_COMPARE = {5'd11, 3'd0};
    localparam logic [7:0] A_STATUS  = {5'd12, 3'd0};
    localparam logic [7:0] A_CAUSE   = {5'd13, 3'd0};
    localparam logic [7:0] A_EPC     = {5'd14, 3'd0};

    logic        clk = 1'b0;
    logic        resetn;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic        wb_delay_slot;
    logic [6:0]  exc_flags;
    logic [31:0] wb_dm_addr;
    logic        mtc0, mfc0, eret;
    logic [7:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic [5:0]  hw_int;
    logic [31:0] cp0_rdata;
    logic        exc_valid;
    logic [31:0] exc_pc;
    logic        cancel;
    logic        commit_block;

    int n_checks = 0;
    int n_fail   = 0;

    cp0_core #(.HW_INT_NUM(6), .COUNT_DIV(2), .EXC_VECTOR(32'hBFC00380)) dut (
        .clk(clk), .resetn(resetn), .wb_valid(wb_valid), .wb_pc(wb_pc),
        .wb_delay_slot(wb_delay_slot), .exc_flags(exc_flags), .wb_dm_addr(wb_dm_addr),
        .mtc0(mtc0), .mfc0(mfc0), .eret(eret), .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata),
        .hw_int(hw_int), .cp0_rdata(cp0_rdata), .exc_valid(exc_valid), .exc_pc(exc_pc),
        .cancel(cancel), .commit_block(commit_block)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in;
        wb_valid = 0; mtc0 = 0; mfc0 = 0; eret = 0; exc_flags = '0;
        wb_delay_slot = 0; wb_pc = '0; wb_dm_addr = '0; cp0_addr = '0; cp0_wdata = '0;
    endtask

    task automatic rdchk(input string tag, input logic [7:0] a, input logic [31:0] exp);
        cp0_addr = a; mfc0 = 1;
        #1;
        chk(tag, cp0_rdata, exp);
        mfc0 = 0;
    endtask

    task automatic rdmask(input string tag, input logic [7:0] a, input logic [31:0] m, input logic [31:0] exp);
        cp0_addr = a; mfc0 = 1;
        #1;
        chk(tag, cp0_rdata & m, exp);
        mfc0 = 0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        idle_in;
        wb_valid = 1; mtc0 = 1; cp0_addr = a; cp0_wdata = d;
        step;
        idle_in;
    endtask

    initial begin
        idle_in;
        hw_int = '0;
        resetn = 0;
        repeat (3) step;
        resetn = 1;

        // Reset state
        rdchk("rst_status", A_STATUS, 32'h0040_0000);
        rdchk("rst_cause", A_CAUSE, 32'h0);
        rdchk("rst_epc", A_EPC, 32'h0);
        rdchk("rst_badv", A_BADV, 32'h0);
        repeat (100) step;
        rdchk("no_spurious_ti", A_CAUSE, 32'h0);

        // Plain instruction: no redirect
        wb_valid = 1; wb_pc = 32'hBFC00100;
        #1;
        chk("nop_exc_valid", exc_valid, 0);
        chk("nop_commit_block", commit_block, 0);
        step; idle_in;

        // Syscall in a delay slot
        wb_valid = 1; wb_pc = 32'hBFC00104; wb_delay_slot = 1; exc_flags = 7'b0001000;
        #1;
        chk("sys_exc_valid", exc_valid, 1);
        chk("sys_exc_pc", exc_pc, 32'hBFC00380);
        chk("sys_cancel", cancel, 1);
        chk("sys_commit_block", commit_block, 1);
        step; idle_in;
        rdchk("sys_epc", A_EPC, 32'hBFC00100);
        rdchk("sys_cause", A_CAUSE, 32'h8000_0020);
        rdchk("sys_status", A_STATUS, 32'h0040_0002);
        wb_valid = 1; eret = 1; wb_pc = 32'h0000_0040;
        #1;
        chk("eret_exc_valid", exc_valid, 1);
        chk("eret_exc_pc", exc_pc, 32'hBFC00100);
        step; idle_in;
        rdchk("eret_status", A_STATUS, 32'h0040_0000);

        // Priority: overflow beats waddr_error, BadVAddr untouched
        wb_valid = 1; wb_pc = 32'h8000_0010; exc_flags = 7'b0010001; wb_dm_addr = 32'h1003;
        step; idle_in;
        rdchk("ov_cause", A_CAUSE, 32'h0000_0030);
        rdchk("ov_badv", A_BADV, 32'h0);
        wb_valid = 1; wb_pc = 32'h8000_0014; exc_flags = 7'b0000001; wb_dm_addr = 32'h1003;
        step; idle_in;
        rdchk("wa_cause", A_CAUSE, 32'h0000_0014);
        rdchk("wa_badv", A_BADV, 32'h0000_1003);
        rdchk("wa_epc", A_EPC, 32'h8000_0014);
        wb_valid = 1; wb_pc = 32'hBFC00200; exc_flags = 7'b1000010; wb_dm_addr = 32'h2000;
        step; idle_in;
        rdchk("fe_cause", A_CAUSE, 32'h0000_0010);
        rdchk("fe_badv", A_BADV, 32'hBFC00200);

        // wb_valid low: nothing taken
        exc_flags = 7'b0001000; wb_pc = 32'h1234_0000;
        #1;
        chk("inv_exc_valid", exc_valid, 0);
        step; idle_in;
        rdchk("inv_cause", A_CAUSE, 32'h0000_0010);

        // mtc0 EPC on a faulting (break) instruction is discarded
        wb_valid = 1; mtc0 = 1; cp0_addr = A_EPC; cp0_wdata = 32'hDEADBEEF;
        exc_flags = 7'b0000100; wb_pc = 32'h8000_1000;
        step; idle_in;
        rdchk("brk_epc", A_EPC, 32'h8000_1000);
        rdchk("brk_cause", A_CAUSE, 32'h0000_0024);

        // Writable fields
        wr(A_STATUS, 32'hFFFF_FFFF);
        rdchk("st_all", A_STATUS, 32'h0040_FF03);
        wr(A_STATUS, 32'h0);
        rdchk("st_clr", A_STATUS, 32'h0040_0000);
        wr(A_CAUSE, 32'hFFFF_FFFF);
        rdchk("cause_sw", A_CAUSE, 32'h0000_0324);
        wr(A_CAUSE, 32'h0);
        rdchk("cause_clr", A_CAUSE, 32'h0000_0024);
        wr(A_EPC, 32'h1234_5678);
        rdchk("epc_wr", A_EPC, 32'h1234_5678);
        wr({5'd14, 3'd1}, 32'h0000_AAAA);
        rdchk("epc_sel1_ignored", A_EPC, 32'h1234_5678);
        rdchk("sel1_reads0", {5'd14, 3'd1}, 32'h0);
        wr(A_BADV, 32'h0);
        rdchk("badv_ro", A_BADV, 32'hBFC00200);
        wr({5'd15, 3'd0}, 32'hFFFF_FFFF);
        rdchk("unimpl_reads0", {5'd15, 3'd0}, 32'h0);

`ifdef CP0_COUNT_TIMER_EN
        // Count write landing on a prescaler wrap wins
        wr(A_COUNT, 32'h100);
        step;
        wr(A_COUNT, 32'h200);
        rdchk("count_wr_wins", A_COUNT, 32'h200);

        // Timer: TI at the edge after Count reaches Compare
        wr(A_COUNT, 32'h0);
        wr(A_COMPARE, 32'h5);
        wr(A_STATUS, 32'h0040_8001);
        repeat (7) step;
        rdchk("tmr_count4", A_COUNT, 32'h4);
        rdmask("tmr_ti_early", A_CAUSE, 32'h4000_0000, 32'h0);
        step;
        rdchk("tmr_count5", A_COUNT, 32'h5);
        rdmask("tmr_ti_match_cycle", A_CAUSE, 32'h4000_0000, 32'h0);
        step;
        rdmask("tmr_ti_set", A_CAUSE, 32'h4000_8000, 32'h4000_8000);
        step;
        wb_valid = 1; wb_pc = 32'h8000_0100;
        #1;
        chk("tmr_int_exc_valid", exc_valid, 1);
        step; idle_in;
        rdmask("tmr_exccode0", A_CAUSE, 32'h0000_007C, 32'h0);
        rdchk("tmr_status", A_STATUS, 32'h0040_8003);
        step;
        wr(A_COMPARE, 32'hFFFF_FFFF);
        rdmask("tmr_ti_cleared", A_CAUSE, 32'h4000_0000, 32'h0);
        rdchk("tmr_compare", A_COMPARE, 32'hFFFF_FFFF);
`else
        wr(A_COUNT, 32'h1234);
        rdchk("count_absent", A_COUNT, 32'h0);
        wr(A_COMPARE, 32'h5);
        rdchk("compare_absent", A_COMPARE, 32'h0);
        repeat (20) step;
        rdmask("ti_absent", A_CAUSE, 32'h4000_0000, 32'h0);
`endif

        // Hardware interrupt on line 2
        wr(A_STATUS, 32'h0000_1001);
        rdchk("hw_status", A_STATUS, 32'h0040_1001);
        hw_int = 6'b000100;
        wb_valid = 1; wb_pc = 32'h8000_2000;
        #1;
        chk("hw_c0", exc_valid, 0);
        step;
        chk("hw_e1", exc_valid, 0);
        step;
        chk("hw_e2", exc_valid, 0);
        rdmask("hw_ip12", A_CAUSE, 32'h0000_1000, 32'h0000_1000);
        step;
        chk("hw_e3_exc_valid", exc_valid, 1);
        chk("hw_e3_exc_pc", exc_pc, 32'hBFC00380);
        step;
        wb_valid = 0;
        rdchk("hw_cause", A_CAUSE, 32'h0000_1000);
        rdchk("hw_status_exl", A_STATUS, 32'h0040_1003);
        rdchk("hw_epc", A_EPC, 32'h8000_2000);
        step;
        wb_valid = 1;
        #1;
        chk("hw_exl_masks", exc_valid, 0);
        step; idle_in;
        hw_int = '0;

        // Reset in the middle of a faulting instruction
        wb_valid = 1; exc_flags = 7'b0001000; wb_pc = 32'h8000_3000;
        resetn = 0;
        #1;
        chk("rst_exc_valid", exc_valid, 0);
        chk("rst_commit_block", commit_block, 0);
        chk("rst_cancel", cancel, 0);
        step;
        idle_in;
        resetn = 1;
        rdchk("rst2_status", A_STATUS, 32'h0040_0000);
        rdchk("rst2_cause", A_CAUSE, 32'h0);
        rdchk("rst2_epc", A_EPC, 32'h0);
        rdchk("rst2_badv", A_BADV, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
